// File: rtl/mem_pkg.sv
// Shared load/store encodings: funct3 size codes, responder FSM states and the
// access-fault rule.
package mem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    // Illegal funct3 codes and natural-alignment violations both fault.
    function automatic logic is_fault(logic [2:0] size, logic [1:0] lsb);
        logic f;
        case (size)
            SZ_B, SZ_BU: f = 1'b0;
            SZ_H, SZ_HU: f = lsb[0];
            SZ_W:        f = (lsb != 2'b00);
            default:     f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Byte-enabled single-clock RAM with registered read, shaped for block-RAM
// inference; contents are deliberately not reset.
module dmem_ram #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's load/store port: one request at a time,
// programmable wait states, lane steering, load extension and fault reporting.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        WE,
    input  logic [2:0]  SIZE,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic        READY,
    output logic [31:0] RDATA,
    output logic        ERR,
    output logic        BUSY
);

    localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q;
    logic [2:0]            size_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  err_q;

    logic                  accept;
    logic                  commit;
    logic                  cur_we;
    logic [2:0]            cur_size;
    logic [ADDR_WIDTH+1:0] cur_addr;
    logic [31:0]           cur_wdata;
    logic [3:0]            ram_be;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;
    logic [31:0]           shifted;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic                  unused_addr;

    assign unused_addr = ^ADDR[31:ADDR_WIDTH+2];

    assign accept = (state_q == StIdle) && REQ;

    // With zero wait states the commit edge is also the acceptance edge, so the
    // live request has to drive the RAM directly.
    always_comb begin
        if (state_q == StIdle) begin
            cur_we    = WE;
            cur_size  = SIZE;
            cur_addr  = ADDR[ADDR_WIDTH+1:0];
            cur_wdata = WDATA;
        end else begin
            cur_we    = we_q;
            cur_size  = size_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (REQ) begin
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign commit = (state_d == StResp) && (state_q != StResp);

    always_comb begin
        ram_be    = 4'b0000;
        ram_wdata = cur_wdata;
        case (cur_size[1:0])
            2'b00: begin
                ram_be    = 4'b0001 << cur_addr[1:0];
                ram_wdata = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                ram_be    = cur_addr[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{cur_wdata[15:0]}};
            end
            2'b10:   ram_be = 4'b1111;
            default: ram_be = 4'b0000;
        endcase
        // RESET gating covers a reset that coincides with the commit edge.
        if (!commit || !cur_we || is_fault(cur_size, cur_addr[1:0]) || RESET) begin
            ram_be = 4'b0000;
        end
    end

    dmem_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (CLK),
        .be   (ram_be),
        .waddr(cur_addr[ADDR_WIDTH+1:2]),
        .wdata(ram_wdata),
        .re   (commit),
        .raddr(cur_addr[ADDR_WIDTH+1:2]),
        .rdata(ram_rdata)
    );

    assign shifted  = ram_rdata >> {addr_q[1:0], 3'b000};
    assign resp_err = is_fault(size_q, addr_q[1:0]);

    always_comb begin
        case (size_q)
            SZ_B:    resp_rdata = {{24{shifted[7]}}, shifted[7:0]};
            SZ_BU:   resp_rdata = {24'd0, shifted[7:0]};
            SZ_H:    resp_rdata = {{16{shifted[15]}}, shifted[15:0]};
            SZ_HU:   resp_rdata = {16'd0, shifted[15:0]};
            SZ_W:    resp_rdata = shifted;
            default: resp_rdata = 32'd0;
        endcase
        if (we_q || resp_err) begin
            resp_rdata = 32'd0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= WE;
                size_q  <= SIZE;
                addr_q  <= ADDR[ADDR_WIDTH+1:0];
                wdata_q <= WDATA;
            end
            if (state_q == StResp) begin
                rdata_q <= resp_rdata;
                err_q   <= resp_err;
            end
        end
    end

    // The response is live during RESP and held afterwards until the next one.
    assign READY = (state_q == StResp);
    assign BUSY  = (state_q != StIdle);
    assign RDATA = READY ? resp_rdata : rdata_q;
    assign ERR   = READY ? resp_err : err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (1, 0 and 3 wait states) driven by
// directed vectors, timing-profile sequences, a reset abort and random traffic.
module tb_dmem_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [3];
    logic        we    [3];
    logic [2:0]  size  [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        err   [3];
    logic        busy  [3];

    int npass  = 0;
    int ntotal = 0;

    logic [31:0] model [1024];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        dmem_responder #(
            .ADDR_WIDTH (10),
            .WAIT_STATES(WS)
        ) u_dut (
            .CLK  (clk),
            .RESET(rst),
            .REQ  (req[g]),
            .WE   (we[g]),
            .SIZE (size[g]),
            .ADDR (addr[g]),
            .WDATA(wdata[g]),
            .READY(ready[g]),
            .RDATA(rdata[g]),
            .ERR  (err[g]),
            .BUSY (busy[g])
        );
    end

    function automatic int ws_of(int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic txn(input int d, input logic w, input logic [2:0] s, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e,
                       output int lat);
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; size[d] = s; addr[d] = a; wdata[d] = wd;
        @(negedge clk);
        req[d] = 1'b0;
        lat = 1;
        while (!ready[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = rdata[d];
        e  = err[d];
    endtask

    task automatic op(input int d, input logic w, input logic [2:0] s, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_e,
                      input string name);
        logic [31:0] rd;
        logic        e;
        int          lat;
        txn(d, w, s, a, wd, rd, e, lat);
        check({name, " rdata"}, rd, exp_rd);
        check({name, " err"}, {31'd0, e}, {31'd0, exp_e});
        check({name, " latency"}, lat, ws_of(d) + 1);
    endtask

    // Reference behaviour expressed directly as byte-level memory semantics.
    function automatic logic ref_fault(logic [2:0] s, logic [31:0] a);
        case (s)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (a % 2) != 0;
            3'd2:       return (a % 4) != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic int ref_bytes(logic [2:0] s);
        return (s[1:0] == 2'b00) ? 1 : ((s[1:0] == 2'b01) ? 2 : 4);
    endfunction

    task automatic ref_access(input logic w, input logic [2:0] s, input logic [31:0] a,
                              input logic [31:0] wd, output logic [31:0] rd, output logic e);
        int          idx;
        int          lane;
        int          n;
        logic [7:0]  b [4];
        logic [31:0] v;
        idx  = int'(a[11:2]);
        lane = int'(a % 4);
        n    = ref_bytes(s);
        e    = ref_fault(s, a);
        rd   = 32'd0;
        for (int k = 0; k < 4; k++) b[k] = 8'(model[idx] >> (8 * k));
        if (!e && w) begin
            for (int k = 0; k < n; k++) b[lane + k] = 8'(wd >> (8 * k));
            model[idx] = {b[3], b[2], b[1], b[0]};
        end else if (!e) begin
            v = 32'd0;
            for (int k = 0; k < n; k++) v = v | (32'(b[lane + k]) << (8 * k));
            if (s == 3'd0) rd = 32'($signed(v[7:0]));
            else if (s == 3'd1) rd = 32'($signed(v[15:0]));
            else rd = v;
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    // Hold REQ high and compare READY/BUSY against the periodic accept pattern.
    task automatic profile(input int d, input int ncyc);
        int p;
        int ph;
        int guard;
        p = ws_of(d) + 2;
        @(negedge clk);
        req[d] = 1'b1; we[d] = 1'b1; size[d] = SZ_W; addr[d] = 32'h100; wdata[d] = $urandom;
        for (int k = 0; k <= ncyc; k++) begin
            if (k > 0) @(negedge clk);
            ph = k % p;
            check($sformatf("d%0d ready k%0d", d, k), {31'd0, ready[d]}, {31'd0, ph == p - 1});
            check($sformatf("d%0d busy k%0d", d, k), {31'd0, busy[d]}, {31'd0, ph != 0});
        end
        req[d] = 1'b0;
        guard = 0;
        while (busy[d] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("d%0d drain", d), {31'd0, busy[d]}, 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] rd, exp_rd;
        logic        e, exp_e;
        int          lat;
        int          nready;
        logic [2:0]  szs [10];
        szs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};

        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; size[d] = 3'd0; addr[d] = 32'd0; wdata[d] = 32'd0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d reset ready", d), {31'd0, ready[d]}, 32'd0);
            check($sformatf("d%0d reset busy", d), {31'd0, busy[d]}, 32'd0);
            check($sformatf("d%0d reset rdata", d), rdata[d], 32'd0);
            check($sformatf("d%0d reset err", d), {31'd0, err[d]}, 32'd0);
        end

        vecs.push_back('{1'b1, SZ_W,   32'h10,       32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, SZ_W,   32'h10,       32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, SZ_W,   32'h20,       32'h0,        32'h0,        1'b0});
        vecs.push_back('{1'b1, SZ_B,   32'h23,       32'hAB,       32'h0,        1'b0});
        vecs.push_back('{1'b0, SZ_W,   32'h20,       32'h0,        32'hAB000000, 1'b0});
        vecs.push_back('{1'b0, SZ_B,   32'h23,       32'h0,        32'hFFFFFFAB, 1'b0});
        vecs.push_back('{1'b0, SZ_BU,  32'h23,       32'h0,        32'h000000AB, 1'b0});
        vecs.push_back('{1'b1, SZ_W,   32'h40,       32'h5555AAAA, 32'h0,        1'b0});
        vecs.push_back('{1'b1, SZ_H,   32'h42,       32'h8001,     32'h0,        1'b0});
        vecs.push_back('{1'b0, SZ_H,   32'h42,       32'h0,        32'hFFFF8001, 1'b0});
        vecs.push_back('{1'b0, SZ_HU,  32'h42,       32'h0,        32'h00008001, 1'b0});
        vecs.push_back('{1'b0, SZ_W,   32'h40,       32'h0,        32'h8001AAAA, 1'b0});
        vecs.push_back('{1'b1, SZ_B,   32'h21,       32'hFFFFFF7F, 32'h0,        1'b0});
        vecs.push_back('{1'b0, SZ_B,   32'h21,       32'h0,        32'h0000007F, 1'b0});
        vecs.push_back('{1'b0, SZ_H,   32'h20,       32'h0,        32'h00007F00, 1'b0});
        vecs.push_back('{1'b0, SZ_HU,  32'h22,       32'h0,        32'h0000AB00, 1'b0});
        vecs.push_back('{1'b0, SZ_H,   32'h22,       32'h0,        32'hFFFFAB00, 1'b0});
        vecs.push_back('{1'b1, SZ_H,   32'h20,       32'hFFFF1234, 32'h0,        1'b0});
        vecs.push_back('{1'b0, SZ_W,   32'h20,       32'h0,        32'hAB001234, 1'b0});
        vecs.push_back('{1'b0, SZ_W,   32'h11,       32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, SZ_H,   32'h13,       32'h1234,     32'h0,        1'b1});
        vecs.push_back('{1'b1, 3'b011, 32'h10,       32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b0, 3'b110, 32'h10,       32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 3'b111, 32'h10,       32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b0, SZ_HU,  32'h41,       32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b0, SZ_W,   32'h10,       32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, SZ_W,   32'h00001010, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, SZ_W,   32'hFFFFF010, 32'h0,        32'hDEADBEEF, 1'b0});
        for (int i = 0; i < vecs.size(); i++) begin
            op(0, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
               vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Response must persist after READY drops, until the next response.
        op(0, 1'b0, SZ_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "hold load");
        @(negedge clk);
        check("hold rdata", rdata[0], 32'hDEADBEEF);
        check("hold ready", {31'd0, ready[0]}, 32'd0);
        check("hold busy", {31'd0, busy[0]}, 32'd0);
        op(0, 1'b0, SZ_W, 32'h12, 32'h0, 32'h0, 1'b1, "hold fault");
        @(negedge clk);
        check("hold err", {31'd0, err[0]}, 32'd1);

        op(1, 1'b1, SZ_W, 32'h8, 32'h0BADF00D, 32'h0, 1'b0, "ws0 store");
        op(1, 1'b0, SZ_W, 32'h8, 32'h0, 32'h0BADF00D, 1'b0, "ws0 load");
        op(2, 1'b1, SZ_B, 32'h9, 32'hC3, 32'h0, 1'b0, "ws3 store");
        op(2, 1'b0, SZ_B, 32'h9, 32'h0, 32'hFFFFFFC3, 1'b0, "ws3 load");
        profile(1, 9);
        profile(2, 16);

        op(2, 1'b1, SZ_W, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0, "pre-reset store");
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b1; size[2] = SZ_W; addr[2] = 32'h0; wdata[2] = 32'h12345678;
        @(negedge clk);
        req[2] = 1'b0;
        @(negedge clk);
        check("abort in wait", {31'd0, busy[2]}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort busy", {31'd0, busy[2]}, 32'd0);
        check("abort rdata", rdata[2], 32'd0);
        nready = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ready[2]) nready++;
        end
        rst = 1'b0;
        check("abort no ready", nready, 0);
        op(2, 1'b0, SZ_W, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, "post-reset load");

        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            txn(0, 1'b1, SZ_W, 32'(i * 4), model[i], rd, e, lat);
            check($sformatf("init%0d lat", i), lat, 2);
        end
        for (int i = 0; i < 150; i++) begin
            logic        w;
            logic [2:0]  s;
            logic [31:0] a, wd;
            w  = 1'($urandom_range(0, 1));
            s  = szs[$urandom_range(0, 9)];
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) * 4)
                 | 32'($urandom_range(0, 3));
            wd = $urandom;
            ref_access(w, s, a, wd, exp_rd, exp_e);
            op(0, w, s, a, wd, exp_rd, exp_e, $sformatf("rnd%0d", i));
        end
        for (int i = 0; i < 16; i++) begin
            op(0, 1'b0, SZ_W, 32'(i * 4), 32'h0, model[i], 1'b0, $sformatf("final%0d", i));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
